axi_burst_bridge: RTL

Parametrised bridge from the core's valid/ready memory request port to a single AXI3 master interface. Supports single-beat and multi-beat bursts (INCR and WRAP), consumer back-pressure on read data, and a write-response wait with error reporting. Sits between the cache/uncached path and the AXI interconnect. It is the burst-capable successor to the single-beat SRAM-to-AXI adapter.

---
 rtl/axi_defs.sv | 40 ++++
 rtl/axi_strb_decode.sv | 38 +++
 rtl/axi_burst_bridge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_defs.sv
// Shared AXI3 encodings and bridge FSM states for the burst bridge and
// related uncached paths.
package axi_defs;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    SIZE_1B = 3'd0,
    SIZE_2B = 3'd1,
    SIZE_4B = 3'd2,
    SIZE_8B = 3'd3
  } size_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WDATA,
    S_WRESP
  } state_t;

  // AXI3 WRAP needs 2/4/8/16 beats; anything else quietly becomes INCR.
  function automatic burst_t burst_type(input logic wrap, input logic [3:0] len);
    if (wrap && (len inside {4'd1, 4'd3, 4'd7, 4'd15})) return BURST_WRAP;
    return BURST_INCR;
  endfunction

endpackage

// File: rtl/axi_strb_decode.sv
// Maps a byte strobe onto an AXI transfer size and the matching low address
// bits; naturally aligned 1/2/4/8-byte patterns narrow, everything else is full width.
module axi_strb_decode
  import axi_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic [STRB_WIDTH-1:0] strb,
  input  logic [ADDR_WIDTH-1:0] addr,
  output size_t                 size,
  output logic [ADDR_WIDTH-1:0] addr_aligned
);

  localparam int LSB = $clog2(STRB_WIDTH);

  logic [LSB-1:0] low;
  logic           unused_addr_low;

  assign unused_addr_low = ^addr[LSB-1:0];

  // NOTE: size/low get defaults before the search loop so no path infers a latch.
  always_comb begin
    size = size_t'(LSB);
    low  = '0;
    for (int s = 0; s < LSB; s++) begin
      for (int k = 0; k < (STRB_WIDTH >> s); k++) begin
        if (strb == STRB_WIDTH'(((1 << (1 << s)) - 1) << (k << s))) begin
          size = size_t'(s);
          low  = LSB'(k << s);
        end
      end
    end
  end

  assign addr_aligned = {addr[ADDR_WIDTH-1:LSB], low};

endmodule

// File: rtl/axi_burst_bridge.sv
// Valid/ready memory request port to single AXI3 master, INCR/WRAP bursts,
// one outstanding transaction, done/err pulse on return to IDLE.
module axi_burst_bridge
  import axi_defs::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         MAX_LEN    = 16,
  localparam int        STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wrap,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic [STRB_WIDTH-1:0] req_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int LSB = $clog2(STRB_WIDTH);

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic                  wrap_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [3:0]            cnt_q, cnt_n;
  logic                  rerr_q, rerr_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic                  accept;
  logic [STRB_WIDTH-1:0] strb_eff;
  size_t                 aw_size;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  unused_ids;

  assign unused_ids = ^{rid, bid};
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    rerr_n    = rerr_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    req_ready = (state_q == S_IDLE);
    rd_valid  = 1'b0;
    rready    = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    bready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_n = req_write ? S_WADDR : S_RADDR;
          cnt_n   = '0;
          rerr_n  = 1'b0;
        end
      end
      S_RADDR: if (arready) state_n = S_RDATA;
      S_RDATA: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        if (rvalid && rd_ready) begin
          rerr_n = rerr_q | (rresp != RESP_OKAY);
          if (rlast) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            err_n   = rerr_n;
          end
        end
      end
      S_WADDR: if (awready) state_n = S_WDATA;
      S_WDATA: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        if (wr_valid && wready) begin
          if (wlast) begin
            state_n = S_WRESP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 4'd1;
          end
        end
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          err_n   = (bresp != RESP_OKAY);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rerr_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rerr_q  <= rerr_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // NOTE: request payload has no reset; it is only read after being loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
      len_q  <= req_len;
      wrap_q <= req_wrap;
      strb_q <= req_strb;
    end
  end

  assign strb_eff = (len_q == 4'd0) ? strb_q : '1;

  axi_strb_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_strb_decode (
    .strb         (strb_eff),
    .addr         (addr_q),
    .size         (aw_size),
    .addr_aligned (aw_addr)
  );

  // Both address valids come straight from the state register, never from the ready.
  assign arvalid = (state_q == S_RADDR);
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = 3'(LSB);
  assign arburst = burst_type(wrap_q, len_q);
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awvalid = (state_q == S_WADDR);
  assign awid    = AXI_ID;
  assign awaddr  = aw_addr;
  assign awlen   = len_q;
  assign awsize  = aw_size;
  assign awburst = burst_type(wrap_q, len_q);
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = AXI_ID;
  assign wdata   = wr_data;
  assign wstrb   = strb_eff;
  assign wlast   = (cnt_q == len_q);

  assign rd_data = rdata;
  assign rd_last = rlast;
  assign done    = done_q;
  assign err     = err_q;

  assert property (@(posedge clk) disable iff (rst) accept |-> (int'(req_len) < MAX_LEN));

endmodule
